// File: rtl/drive_pkg.sv
// drive_pkg: shared drive-path types and default timing constants for the wheel PWM channels.
package drive_pkg;

    localparam int DEF_CNT_W     = 21;
    localparam int DEF_NEUTRAL_W = 150000;
    localparam int DEF_FWD_W     = 200000;
    localparam int DEF_REV_W     = 100000;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        FWD  = 2'd1,
        REV  = 2'd2,
        HOLD = 2'd3
    } motor_cmd_t;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        PULSE     = 2'd1,
        REST      = 2'd2
    } pwm_state_t;

endpackage

// File: rtl/cmd_slot.sv
// cmd_slot: single-entry valid/ready holding register; the entry is released by the apply strobe.
module cmd_slot #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         apply,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic         full_d, full_q;
    logic [W-1:0] data_d, data_q;
    logic         accept;

    // An accept only happens while empty, so it wins over a simultaneous apply.
    always_comb begin
        accept = in_valid && !full_q;
        full_d = accept ? 1'b1 : (apply ? 1'b0 : full_q);
        data_d = accept ? in_data : data_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign in_ready  = !full_q;
    assign out_valid = full_q;
    assign out_data  = data_q;

endmodule

// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: one servo PWM channel synced to the free-running timebase; commands switch only at period boundaries.
module servo_pwm_gen import drive_pkg::*; #(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int NEUTRAL_W = DEF_NEUTRAL_W,
    parameter int FWD_W     = DEF_FWD_W,
    parameter int REV_W     = DEF_REV_W,
    parameter bit INVERT    = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] count,
    input  logic [1:0]       cmd,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    output logic             pwm,
    output logic             period_start,
    output logic [1:0]       active_cmd
);

    localparam logic [CNT_W-1:0] NEU_C = CNT_W'(NEUTRAL_W);
    localparam logic [CNT_W-1:0] FWD_C = INVERT ? CNT_W'(REV_W) : CNT_W'(FWD_W);
    localparam logic [CNT_W-1:0] REV_C = INVERT ? CNT_W'(FWD_W) : CNT_W'(REV_W);

    pwm_state_t       state_d, state_q;
    motor_cmd_t       active_d, active_q;
    logic             pwm_d, pwm_q;
    logic             ps_d, ps_q;
    logic             boundary;
    logic             pend_valid;
    logic [1:0]       pend_data;
    logic [CNT_W-1:0] width;

    cmd_slot #(.W(2)) u_slot (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_data  (cmd),
        .in_valid (cmd_valid),
        .in_ready (cmd_ready),
        .apply    (boundary),
        .out_valid(pend_valid),
        .out_data (pend_data)
    );

    // The width for a new period comes from the command being applied at that boundary.
    always_comb begin
        boundary = count == '0;
        active_d = (boundary && pend_valid) ? motor_cmd_t'(pend_data) : active_q;
        width    = (active_d == STOP) ? NEU_C :
                   (active_d == FWD)  ? FWD_C :
                   (active_d == REV)  ? REV_C : '0;
        state_d  = boundary ? ((width == '0) ? REST : PULSE) :
                   (state_q == PULSE && count >= width) ? REST : state_q;
        pwm_d    = state_d == PULSE;
        ps_d     = boundary;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= WAIT_SYNC;
            active_q <= STOP;
            pwm_q    <= 1'b0;
            ps_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
            ps_q     <= ps_d;
        end
    end

    assign pwm          = pwm_q;
    assign period_start = ps_q;
    assign active_cmd   = active_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// tb_servo_pwm_gen: directed checks of a scaled-down channel (1024-cycle period) plus a mirrored instance.
module tb_servo_pwm_gen;

    localparam int CW = 10;

    logic          clk;
    logic          reset_n;
    logic [CW-1:0] count;
    logic [1:0]    cmd;
    logic          cmd_valid;
    logic          cmd_ready, pwm, period_start;
    logic [1:0]    active_cmd;
    logic          cmd_ready_i, pwm_i, period_start_i;
    logic [1:0]    active_cmd_i;

    int checks = 0;
    int errors = 0;
    int hi, hi_i, ps;

    servo_pwm_gen #(.CNT_W(CW), .NEUTRAL_W(150), .FWD_W(200), .REV_W(100), .INVERT(1'b0)) dut (
        .clk(clk), .reset_n(reset_n), .count(count), .cmd(cmd), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .pwm(pwm), .period_start(period_start), .active_cmd(active_cmd)
    );

    servo_pwm_gen #(.CNT_W(CW), .NEUTRAL_W(150), .FWD_W(200), .REV_W(100), .INVERT(1'b1)) dut_i (
        .clk(clk), .reset_n(reset_n), .count(count), .cmd(cmd), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready_i), .pwm(pwm_i), .period_start(period_start_i), .active_cmd(active_cmd_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input integer obs, input integer exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        count = count + 1'b1;
        hi   += int'(pwm);
        hi_i += int'(pwm_i);
        ps   += int'(period_start);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clr();
        hi = 0;
        hi_i = 0;
        ps = 0;
    endtask

    initial begin
        reset_n = 1'b1;
        count = 5;
        cmd = 2'd0;
        cmd_valid = 1'b0;
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pwm", pwm, 0);
        chk("rst_ps", period_start, 0);
        chk("rst_active", active_cmd, 0);
        chk("rst_ready", cmd_ready, 1);
        reset_n = 1'b1;
        count = 5;
        clr();
        run(1019);
        chk("presync_hi", hi, 0);
        chk("presync_ps", ps, 0);
        // First period: STOP, FWD accepted at count 10 during the pulse
        clr();
        tick();
        chk("p1_ps", period_start, 1);
        chk("p1_pwm_rise", pwm, 1);
        run(9);
        cmd = 2'd1;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("fwd_ready_drop", cmd_ready, 0);
        chk("fwd_not_yet", active_cmd, 0);
        run(139);
        chk("p1_pwm_149", pwm, 1);
        tick();
        chk("p1_pwm_150", pwm, 0);
        chk("p1_ps_low", period_start, 0);
        run(873);
        chk("p1_hi", hi, 150);
        chk("p1_hi_inv", hi_i, 150);
        chk("p1_ps_cnt", ps, 1);
        // FWD period; mirrored instance uses REV width
        clr();
        tick();
        chk("fwd_active", active_cmd, 1);
        chk("fwd_active_inv", active_cmd_i, 1);
        chk("fwd_ready_rise", cmd_ready, 1);
        run(1023);
        chk("fwd_hi", hi, 200);
        chk("fwd_hi_inv", hi_i, 100);
        chk("fwd_ps_cnt", ps, 1);
        // HOLD accepted during FWD period
        clr();
        run(5);
        cmd = 2'd3;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        run(1018);
        chk("prehold_hi", hi, 200);
        clr();
        tick();
        chk("hold_active", active_cmd, 3);
        chk("hold_pwm", pwm, 0);
        run(9);
        cmd = 2'd0;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        run(1013);
        chk("hold_hi", hi, 0);
        chk("hold_ps_cnt", ps, 1);
        clr();
        run(1024);
        chk("stop_restore_hi", hi, 150);
        chk("stop_restore_active", active_cmd, 0);
        // REV accepted, STOP held valid while not ready
        clr();
        run(10);
        cmd = 2'd2;
        cmd_valid = 1'b1;
        tick();
        cmd = 2'd0;
        chk("b2b_ready_low", cmd_ready, 0);
        run(1013);
        chk("b2b_stop_hi", hi, 150);
        chk("b2b_active_stop", active_cmd, 0);
        clr();
        tick();
        chk("rev_active", active_cmd, 2);
        chk("rev_ready_rise", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        chk("stop_accepted", cmd_ready, 0);
        run(1022);
        chk("rev_hi", hi, 100);
        chk("rev_hi_inv", hi_i, 200);
        clr();
        tick();
        chk("stop_after_rev", active_cmd, 0);
        run(1023);
        chk("stop_after_rev_hi", hi, 150);
        // Accept exactly at a count==0 sample defers one period
        cmd = 2'd1;
        cmd_valid = 1'b1;
        clr();
        tick();
        cmd_valid = 1'b0;
        chk("zero_accept_active", active_cmd, 0);
        chk("zero_accept_ready", cmd_ready, 0);
        run(1023);
        chk("zero_accept_hi", hi, 150);
        clr();
        tick();
        chk("deferred_active", active_cmd, 1);
        run(1023);
        chk("deferred_hi", hi, 200);
        // Reset mid-pulse with a command pending
        run(10);
        cmd = 2'd2;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        run(39);
        chk("mid_pwm_high", pwm, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_pwm", pwm, 0);
        chk("async_active", active_cmd, 0);
        chk("async_ready", cmd_ready, 1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        count = 60;
        clr();
        run(964);
        chk("postrst_hi", hi, 0);
        chk("postrst_ps", ps, 0);
        clr();
        run(1024);
        chk("postrst_period_hi", hi, 150);
        chk("postrst_period_ps", ps, 1);
        chk("postrst_active", active_cmd, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
